nnrv_prefetch: RTL

Instruction prefetch queue between RAM read port 1 and nnrv_if. It reads sequential instruction words into a small FIFO ahead of the fetch stage, so fetch sees a valid/ready stream instead of raw RAM timing. A flush from decode (taken jump or branch) discards all buffered and in-flight words and restarts fetching at the new PC.

---
 rtl/nnrv_prefetch.sv | 109 ++++++++++
 1 files changed

// File: rtl/nnrv_prefetch.sv
// Instruction prefetch queue: streams sequential words from RAM port 1 into a
// small FIFO ahead of fetch. A decode flush drops everything and restarts at the target.
module nnrv_prefetch #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int XLEN        = 32,
  parameter int DEPTH       = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  output logic [ADDR_WIDTH-1:0]  o_ram_rd_addr,
  output logic                   o_ram_rd_en,
  output logic [3:0]             o_ram_rd_mask,
  input  logic [INSTR_WIDTH-1:0] i_ram_rd_data,
  input  logic                   i_flush,
  input  logic [XLEN-1:0]        i_flush_pc,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [XLEN-1:0]        o_pc,
  output logic                   o_valid,
  input  logic                   i_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic             inflight_q, inflight_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  entry_t           mem_q [DEPTH];

  logic             issue, push, pop, has_room;
  logic [CNT_W:0]   occ;
  entry_t           head;

  // The in-flight word already owns a slot, so it counts against capacity.
  assign occ      = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(inflight_q);
  assign has_room = occ < (CNT_W+1)'(DEPTH);
  // Gating with reset keeps the strobe low the instant reset asserts.
  assign issue    = i_rst & ~i_flush & has_room;
  assign push     = inflight_q & ~i_flush;
  assign pop      = o_valid & i_ready & ~i_flush;

  assign o_ram_rd_en   = issue;
  assign o_ram_rd_addr = fetch_pc_q[ADDR_WIDTH+1:2];
  assign o_ram_rd_mask = issue ? 4'b1111 : 4'b0000;

  assign head    = mem_q[rd_ptr_q];
  assign o_valid = (cnt_q != '0);
  assign o_instr = o_valid ? head.instr : NOP;
  assign o_pc    = o_valid ? head.pc    : '0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    if (i_flush) begin
      fetch_pc_d = i_flush_pc & ~XLEN'(3);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + XLEN'(4);
        inflight_pc_d = fetch_pc_q;
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
    end
  end

  // Storage needs no reset: cnt_q gates every read.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: inflight_pc_q, instr: i_ram_rd_data};
  end

endmodule
